// File: rtl/vga_frame_monitor.sv
// VGA receive-side frame monitor: recovers pixel x/y from sampled sync/RGB, checks line and
// frame timing, and reports frame statistics. Define VGA_MON_CRC_EN to add the frame_crc output.
module vga_frame_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [11:0] rgb,
    input  logic        err_clr,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        frame_done,
    output logic        locked,
    output logic        err_h,
    output logic        err_v,
    output logic [15:0] frame_count,
    output logic [18:0] dark_count
`ifdef VGA_MON_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  Y_LAST  = 9'(V_ACTIVE - 1);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
    state_t state_reg, state_next;

    logic        h_prev_reg, v_prev_reg;
    logic        h_seen_reg, v_seen_reg;
    logic        vs_pend_reg, vs_pend_next;
    logic [10:0] h_cnt_reg, h_cnt_next;
    logic [9:0]  v_cnt_reg, v_cnt_next;
    logic [18:0] acc_reg, acc_next;

    logic       h_fall, v_fall, v_reset, h_bad, v_bad;
    logic       in_win, emit, first_px, last_px, dark;
    logic [9:0] x_next;
    logic [8:0] y_next;

    // Edge detection and raster counters; everything holds on cycles without pix_ce.
    always_comb begin
        h_fall       = pix_ce & h_prev_reg & ~h_sync;
        v_fall       = pix_ce & v_prev_reg & ~v_sync;
        v_reset      = h_fall & (vs_pend_reg | v_fall);
        h_bad        = h_fall & h_seen_reg & (h_cnt_reg != H_LAST);
        v_bad        = v_reset & v_seen_reg & (v_cnt_reg != V_LAST);
        h_cnt_next   = h_cnt_reg;
        v_cnt_next   = v_cnt_reg;
        vs_pend_next = vs_pend_reg;
        if (pix_ce) begin
            if (h_fall)
                h_cnt_next = '0;
            else if (h_cnt_reg != 11'h7FF)
                h_cnt_next = h_cnt_reg + 11'd1;
            if (v_reset) begin
                v_cnt_next   = '0;
                vs_pend_next = 1'b0;
            end else begin
                if (h_fall)
                    v_cnt_next = v_cnt_reg + 10'd1;
                if (v_fall)
                    vs_pend_next = 1'b1;
            end
        end
    end

    // A timing error in the same sample overrides any lock progress.
    always_comb begin
        state_next = state_reg;
        if (h_bad || v_bad) begin
            state_next = SEARCH;
        end else if (v_reset) begin
            case (state_reg)
                SEARCH:  state_next = TRACK;
                TRACK:   state_next = LOCKED;
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        in_win   = (h_cnt_next >= H_START) && (h_cnt_next <= H_END) &&
                   (v_cnt_next >= V_START) && (v_cnt_next <= V_END);
        emit     = pix_ce & (state_next == LOCKED) & in_win;
        x_next   = 10'(h_cnt_next - H_START);
        y_next   = 9'(v_cnt_next - V_START);
        first_px = emit && (x_next == 10'd0) && (y_next == 9'd0);
        last_px  = emit && (x_next == X_LAST) && (y_next == Y_LAST);
        dark     = (rgb == 12'd0);
        acc_next = acc_reg;
        if (state_next != LOCKED)
            acc_next = '0;
        else if (first_px)
            acc_next = 19'(dark);
        else if (emit)
            acc_next = acc_reg + 19'(dark);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= SEARCH;
            h_prev_reg  <= 1'b0;
            v_prev_reg  <= 1'b0;
            h_seen_reg  <= 1'b0;
            v_seen_reg  <= 1'b0;
            vs_pend_reg <= 1'b0;
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
            acc_reg     <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_h       <= 1'b0;
            err_v       <= 1'b0;
            frame_count <= '0;
            dark_count  <= '0;
        end else begin
            state_reg   <= state_next;
            h_cnt_reg   <= h_cnt_next;
            v_cnt_reg   <= v_cnt_next;
            vs_pend_reg <= vs_pend_next;
            acc_reg     <= acc_next;
            if (pix_ce) begin
                h_prev_reg <= h_sync;
                v_prev_reg <= v_sync;
            end
            if (h_fall)
                h_seen_reg <= 1'b1;
            if (v_reset)
                v_seen_reg <= 1'b1;
            pix_valid   <= emit;
            frame_start <= first_px;
            frame_done  <= last_px;
            if (emit) begin
                pix_x   <= x_next;
                pix_y   <= y_next;
                pix_rgb <= rgb;
            end
            if (last_px) begin
                dark_count  <= acc_next;
                frame_count <= frame_count + 16'd1;
            end
            // A new error beats a simultaneous clear.
            err_h <= h_bad | (err_h & ~err_clr);
            err_v <= v_bad | (err_v & ~err_clr);
        end
    end

    assign locked = (state_reg == LOCKED);

`ifdef VGA_MON_CRC_EN
    function automatic logic [15:0] crc_step12(input logic [15:0] crc_in, input logic [11:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 11; i >= 0; i--) begin
            if (c[15] ^ data[i])
                c = {c[14:0], 1'b0} ^ 16'h1021;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [15:0] crc_reg, crc_upd;

    assign crc_upd = crc_step12(first_px ? 16'hFFFF : crc_reg, rgb);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_reg   <= '0;
            frame_crc <= '0;
        end else begin
            if (emit)
                crc_reg <= crc_upd;
            if (last_px)
                frame_crc <= crc_upd;
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor using a reduced raster so many frames fit in a short run.
module tb_vga_frame_monitor;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_ce = 1'b0;
    logic        h_sync = 1'b1;
    logic        v_sync = 1'b1;
    logic [11:0] rgb = '0;
    logic        err_clr = 1'b0;
    logic        pix_valid, frame_start, frame_done, locked, err_h, err_v;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [11:0] pix_rgb;
    logic [15:0] frame_count;
    logic [18:0] dark_count;
`ifdef VGA_MON_CRC_EN
    logic [15:0] frame_crc;
`endif

    vga_frame_monitor #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .h_sync(h_sync), .v_sync(v_sync),
        .rgb(rgb), .err_clr(err_clr), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .frame_start(frame_start), .frame_done(frame_done),
        .locked(locked), .err_h(err_h), .err_v(err_v), .frame_count(frame_count),
        .dark_count(dark_count)
`ifdef VGA_MON_CRC_EN
        , .frame_crc(frame_crc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] c;
        logic        fs;
        logic        fd;
        logic [18:0] dark;
        logic [15:0] fc;
        logic [15:0] crc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: lock stage 0 = searching, 1 = one frame boundary seen, 2 = locked.
    int          m_stage;
    bit          m_have_line, m_have_frame;
    int          m_prev_len, m_lines;
    bit          m_err_h, m_err_v;
    logic [15:0] m_fc;
    logic [18:0] m_acc;
    logic [15:0] m_crc;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [11:0] d);
        logic [15:0] r;
        r = crc;
        for (int b = 11; b >= 0; b--) begin
            logic top;
            top = r[15] ^ d[b];
            r = r << 1;
            if (top) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    function automatic logic [11:0] pick(input int mode, input int ax, input int ay);
        if (mode == 1) return 12'h000;
        if (mode == 2) return (ax >= 3 && ax <= 8 && ay >= 2 && ay <= 5) ? 12'h000 : 12'hFFF;
        if ($urandom_range(0, 3) == 0) return 12'h000;
        return 12'($urandom_range(1, 4095));
    endfunction

    task automatic model_reset();
        m_stage = 0; m_have_line = 0; m_have_frame = 0; m_prev_len = 0; m_lines = 0;
        m_err_h = 0; m_err_v = 0; m_fc = '0; m_acc = '0; m_crc = '0;
    endtask

    // Judge the previous line and frame when a new line begins.
    task automatic model_line_start(input bit frame_begin, input int len);
        bit eh, ev;
        eh = m_have_line && (m_prev_len != HT);
        ev = frame_begin && m_have_frame && (m_lines != VT);
        if (eh) m_err_h = 1;
        if (ev) m_err_v = 1;
        if (eh || ev) m_stage = 0;
        else if (frame_begin && m_stage < 2) m_stage++;
        if (frame_begin) begin
            m_have_frame = 1;
            m_lines = 1;
        end else begin
            m_lines++;
        end
        m_have_line = 1;
        m_prev_len = len;
    endtask

    task automatic model_pixel(input int ax, input int ay, input logic [11:0] c);
        exp_t e;
        if (ax == 0 && ay == 0) begin
            m_acc = '0;
            m_crc = 16'hFFFF;
        end
        if (c == 12'h000) m_acc = m_acc + 19'd1;
        m_crc = ref_crc(m_crc, c);
        e.x = ax; e.y = ay; e.c = c;
        e.fs = (ax == 0 && ay == 0);
        e.fd = (ax == HA - 1 && ay == VA - 1);
        if (e.fd) m_fc = m_fc + 16'd1;
        e.dark = m_acc; e.fc = m_fc; e.crc = m_crc;
        exp_q.push_back(e);
    endtask

    // Entry and exit point: one time unit after a rising edge.
    task automatic send(input logic h, input logic v, input logic [11:0] c);
        int idle = $urandom_range(0, 2);
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        h_sync = h; v_sync = v; rgb = c; pix_ce = 1'b1;
        @(posedge clk);
        #1;
        pix_ce = 1'b0;
    endtask

    task automatic idle_samples(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 1'b1, 12'($urandom_range(0, 4095)));
    endtask

    task automatic drive_frame(input int nlines, input int stretch_line, input int mode,
                               input int abort_line, input int abort_px);
        for (int l = 0; l < nlines; l++) begin
            int len = (l == stretch_line) ? HT + 1 : HT;
            model_line_start(l == 0, len);
            for (int p = 0; p < len; p++) begin
                int ax = p - (HS + HB);
                int ay = l - (VS + VB);
                bit act = (ax >= 0) && (ax < HA) && (ay >= 0) && (ay < VA);
                logic [11:0] c;
                if (l == abort_line && p == abort_px) return;
                c = pick(mode, ax, ay);
                if (act && m_stage == 2) model_pixel(ax, ay, c);
                send(p >= HS, l >= VS, c);
            end
        end
    endtask

    task automatic check_status();
        check("locked", locked, m_stage == 2);
        check("err_h", err_h, m_err_h);
        check("err_v", err_v, m_err_v);
        check("frame_count", frame_count, m_fc);
    endtask

    task automatic check_all_zero();
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_pix_rgb", pix_rgb, 0);
        check("rst_pulses", {frame_start, frame_done}, 0);
        check("rst_locked", locked, 0);
        check("rst_errs", {err_h, err_v}, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_dark_count", dark_count, 0);
`ifdef VGA_MON_CRC_EN
        check("rst_frame_crc", frame_crc, 0);
`endif
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_err_h = 0;
        m_err_v = 0;
        check("err_h_cleared", err_h, m_err_h);
        check("err_v_cleared", err_v, m_err_v);
    endtask

    // Scoreboard monitor: every presented pixel is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (pix_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pixel: got x=%0d y=%0d expected no pixel", pix_x, pix_y);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pixel", {pix_x, pix_y, pix_rgb, frame_start, frame_done},
                          {10'(mon_e.x), 9'(mon_e.y), mon_e.c, mon_e.fs, mon_e.fd});
                    if (mon_e.fd) begin
                        check("dark_count", dark_count, mon_e.dark);
                        check("frame_done_count", frame_count, mon_e.fc);
`ifdef VGA_MON_CRC_EN
                        check("frame_crc", frame_crc, mon_e.crc);
`endif
                        $display("frame done: frame_count=%0d dark_count=%0d", frame_count, dark_count);
                    end
                end
            end else if (frame_start || frame_done) begin
                check("stray_pulse", {frame_start, frame_done}, 0);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        reset = 1'b0;
        idle_samples(3);

        // Random frames: lock on the second frame boundary.
        for (int f = 0; f < 4; f++) begin
            drive_frame(VT, -1, 0, -1, -1);
            check_status();
        end

        // White frame with a dark rectangle.
        drive_frame(VT, -1, 2, -1, -1);
        check_status();

        // One over-long active line.
        drive_frame(VT, VS + VB + 3, 0, -1, -1);
        check_status();
        for (int f = 0; f < 3; f++) begin
            drive_frame(VT, -1, 0, -1, -1);
            check_status();
        end
        clear_errors();

        // A frame one line short.
        drive_frame(VT - 1, -1, 0, -1, -1);
        check_status();
        for (int f = 0; f < 3; f++) begin
            drive_frame(VT, -1, 0, -1, -1);
            check_status();
        end
        clear_errors();

        // Reset in the middle of a locked frame.
        drive_frame(VT, -1, 0, VS + VB + 4, HS + HB + 8);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero();
        check("queue_drained_before_reset", exp_q.size(), 0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_samples(3);
        for (int f = 0; f < 3; f++) begin
            drive_frame(VT, -1, 0, -1, -1);
            check_status();
        end

        // All-black frame.
        drive_frame(VT, -1, 1, -1, -1);
        check_status();

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
- Receive-side counterpart of the VGA display controller: samples hSync, vSync and 12-bit RGB on the 100 MHz system clock and recovers pixel coordinates.
- Locks to standard 640x480@60 timing, flags sync-timing errors, and streams recovered active pixels with x/y.
- Produces per-frame statistics (frame count, dark-pixel count).
- Used in simulation benches and as an on-board self-check tap of the VGA pins.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hSync low width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vSync low width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clk  in  1  100 MHz system clock
reset  in  1  asynchronous, active-high
pix_ce  in  1  one-clk strobe per pixel (25 MHz rate); sampling only when high
h_sync  in  1  horizontal sync, active-low
v_sync  in  1  vertical sync, active-low
rgb  in  12  {R,G,B} pixel colour
err_clr  in  1  clears sticky error flags
pix_valid  out  1  recovered active pixel strobe
pix_x  out  10  recovered column 0..639
pix_y  out  9  recovered row 0..479
pix_rgb  out  12  recovered colour
frame_start  out  1  pulse with pixel (0,0)
frame_done  out  1  pulse with pixel (639,479)
locked  out  1  timing lock indicator
err_h  out  1  sticky: bad line period
err_v  out  1  sticky: bad frame line count
frame_count  out  16  completed frames while locked, wraps
dark_count  out  19  rgb==0 pixels in last completed frame

Behaviour:
- Reset: all outputs 0; FSM in SEARCH; all counters 0.
- Sampling: on clk with pix_ce=1, register h_sync, v_sync, rgb. Edges are detected against the previous sample. Nothing changes on clk cycles with pix_ce=0.
- h_cnt (11 bit, saturates at 2047):
  - Set to 0 on an hSync-falling sample; otherwise +1 per sample.
- Line period check: at each hSync fall after the first, h_cnt must equal H_TOTAL-1 (799), else err_h.
- Vertical pending flag: a vSync-falling sample sets vs_pend.
- v_cnt (10 bit):
  - At the next hSync fall (the same sample counts), v_cnt <= 0 and vs_pend clears. This is a "v-reset".
  - Any other hSync fall increments v_cnt.
- Frame line-count check: at each v-reset after the first, v_cnt must equal V_TOTAL-1 (524), else err_v.
- Active window: h_cnt in [144,783] and v_cnt in [35,514]; x = h_cnt-144, y = v_cnt-35.
- FSM:
  - SEARCH -> TRACK on first v-reset.
  - TRACK -> LOCKED on next v-reset with correct count and no error since entering TRACK.
  - Any error in TRACK/LOCKED -> SEARCH.
  - locked = (state==LOCKED).
- Error behaviour: an error sets its sticky flag. err_clr clears both flags the following clk. If err_clr and a new error occur in the same cycle, the error wins.
- Output latency: pix_valid, pix_x, pix_y, pix_rgb are registered, valid in the clk after the sampling pix_ce, high exactly one clk. Emitted only when LOCKED and inside the active window.
- frame_start / frame_done: one-clk pulses coincident with pix_valid at (0,0) and (639,479).
- Statistics:
  - dark accumulator clears at (0,0) and adds 1 per rgb==0 active pixel.
  - On frame_done, dark_count <= final accumulator value (including the last pixel) and frame_count increments (wraps at 65535).
- Lock loss mid-frame: the accumulator is discarded; dark_count holds its previous value.
- Reset mid-frame: immediate return to reset state; relock requires two v-resets.

Optional Feature:
VGA_MON_CRC_EN:
- When defined, adds output frame_crc[15:0]: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) over the 12-bit rgb of every active pixel in raster order.
- Latched on frame_done; reset value 0.
- When undefined, the port and logic are absent.

Test Plan:
- Reset, drive clean 640x480 white frames: locked=1 at the start of the 2nd v-reset; 307200 pix_valid per frame; first pixel x=0,y=0; frame_done at x=639,y=479; frame_count=1 after the first locked frame; err_h=err_v=0.
- White frame with a 60x60 rgb=0 square at (100,255): dark_count=3600; pixels at (100,255) and (159,314) report rgb=0, pixel (160,255) reports 0xFFF.
- One line stretched to 801 pixels in a locked frame: err_h=1, locked=0 the next clk, no pix_valid until relock two v-resets later; err_clr -> err_h=0.
- Frame with 524 lines: err_v=1, locked drops at that v-reset, frame_count unchanged.
- Assert reset at pixel (320,240): all outputs 0 immediately; relock after two subsequent v-resets with frame_count restarting at 0.
- VGA_MON_CRC_EN with all-0x000 frame: frame_crc matches the bench's reference CRC model; with the macro off, the design compiles without the frame_crc port.
